// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle of the decode stage
interface decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_regwrite;
  logic        out_memtoreg;
  logic        out_memwrite;
  logic        out_alusrcbimm;
  logic        out_slt;
  logic        out_shift16left;
  logic        out_zeroextend;
  logic        out_dojal;
  logic        out_dojr;
  logic        out_dojump;
  logic        out_isbranch;
  logic        out_branchneg;
  logic [4:0]  out_destreg;
  logic [2:0]  out_alucontrol;
  logic        out_illegal;
  logic        muldiv_start;
  logic        muldiv_busy;
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_regwrite, out_memtoreg,
           out_memwrite, out_alusrcbimm, out_slt, out_shift16left, out_zeroextend,
           out_dojal, out_dojr, out_dojump, out_isbranch, out_branchneg,
           out_destreg, out_alucontrol, out_illegal, muldiv_start, muldiv_busy
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_regwrite, out_memtoreg,
           out_memwrite, out_alusrcbimm, out_slt, out_shift16left, out_zeroextend,
           out_dojal, out_dojr, out_dojump, out_isbranch, out_branchneg,
           out_destreg, out_alucontrol, out_illegal, muldiv_start, muldiv_busy
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered MIPS decode stage with mul/div scoreboard, load-use interlock and flush
module decode_stage #(
  parameter int MULDIV_CYCLES      = 8,
  parameter bit LOAD_USE_INTERLOCK = 1'b1
) (
  input logic     clk,
  input logic     reset_n,
  decode_if.slave bus
);
  typedef struct packed {
    logic       illegal;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrcbimm;
    logic       slt;
    logic       shift16left;
    logic       zeroextend;
    logic       dojal;
    logic       dojr;
    logic       dojump;
    logic       isbranch;
    logic       branchneg;
    logic [4:0] destreg;
    logic [2:0] alucontrol;
  } ctrl_t;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  ctrl_t       d, q;
  logic        q_valid, start;
  logic [31:0] q_instr, q_pc;
  logic [7:0]  cnt;
  logic        is_md, is_hilo, uses_rt, lu_hit, stall, accept;
  assign op = bus.in_instr[31:26];
  assign rs = bus.in_instr[25:21];
  assign rt = bus.in_instr[20:16];
  assign rd = bus.in_instr[15:11];
  assign fn = bus.in_instr[5:0];
  // decode the incoming word; anything unsupported collapses to a bare illegal flag
  always_comb begin
    d = '0;
    case (op)
      6'b000000: begin
        d.regwrite = 1'b1;
        d.destreg  = rd;
        case (fn)
          6'b100001: d.alucontrol = 3'b010;
          6'b100011: d.alucontrol = 3'b110;
          6'b100100: d.alucontrol = 3'b000;
          6'b100101: d.alucontrol = 3'b001;
          6'b011011: d.alucontrol = 3'b111;
          6'b011001: d.alucontrol = 3'b011;
          6'b010000: d.alucontrol = 3'b100;
          6'b010010: d.alucontrol = 3'b101;
          6'b101011: d.slt = 1'b1;
          6'b001000: begin
            d.regwrite = 1'b0;
            d.destreg  = 5'd0;
            d.dojr     = 1'b1;
          end
          default: begin
            d         = '0;
            d.illegal = 1'b1;
          end
        endcase
      end
      6'b100011: begin
        d.regwrite   = 1'b1;
        d.memtoreg   = 1'b1;
        d.alusrcbimm = 1'b1;
        d.alucontrol = 3'b010;
        d.destreg    = rt;
      end
      6'b101011: begin
        d.memwrite   = 1'b1;
        d.alusrcbimm = 1'b1;
        d.alucontrol = 3'b010;
      end
      6'b000100: begin
        d.isbranch   = 1'b1;
        d.alucontrol = 3'b110;
      end
      6'b000001: begin
        d.isbranch  = 1'b1;
        d.slt       = 1'b1;
        d.branchneg = 1'b1;
      end
      6'b001001: begin
        d.regwrite   = 1'b1;
        d.alusrcbimm = 1'b1;
        d.alucontrol = 3'b010;
        d.destreg    = rt;
      end
      6'b001101: begin
        d.regwrite   = 1'b1;
        d.zeroextend = 1'b1;
        d.alusrcbimm = 1'b1;
        d.alucontrol = 3'b001;
        d.destreg    = rt;
      end
      6'b001111: begin
        d.regwrite    = 1'b1;
        d.shift16left = 1'b1;
        d.alusrcbimm  = 1'b1;
        d.alucontrol  = 3'b010;
        d.destreg     = rt;
      end
      6'b000010: d.dojump = 1'b1;
      6'b000011: begin
        d.dojump   = 1'b1;
        d.dojal    = 1'b1;
        d.regwrite = 1'b1;
        d.destreg  = 5'd31;
      end
      default: d.illegal = 1'b1;
    endcase
  end
  assign is_md   = op == 6'b000000 && (fn == 6'b011011 || fn == 6'b011001);
  assign is_hilo = op == 6'b000000 && (fn == 6'b010000 || fn == 6'b010010);
  assign uses_rt = op == 6'b000000 || op == 6'b000100 || op == 6'b101011;
  assign lu_hit  = LOAD_USE_INTERLOCK && q_valid && q.memtoreg && q.destreg != 5'd0 &&
                   (q.destreg == rs || (uses_rt && q.destreg == rt));
  assign stall   = (cnt != 8'd0 && (is_md || is_hilo)) || lu_hit;
  assign bus.in_ready = !bus.flush && !stall && (!q_valid || bus.out_ready);
  assign accept  = bus.in_valid && bus.in_ready;
  // output register: load on accept, drop valid on flush or on a transfer with no replacement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
      q       <= '0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (accept) begin
      q_valid <= 1'b1;
      q       <= d;
      q_instr <= bus.in_instr;
      q_pc    <= bus.in_pc;
    end else if (bus.flush || bus.out_ready) begin
      q_valid <= 1'b0;
    end
  end
  // HI/LO occupancy counter; free-running down to zero once a mul/div issues
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= 8'd0;
      start <= 1'b0;
    end else begin
      start <= accept && is_md;
      cnt   <= (accept && is_md) ? 8'(MULDIV_CYCLES) : (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
    end
  end
  assign bus.out_valid       = q_valid;
  assign bus.out_instr       = q_instr;
  assign bus.out_pc          = q_pc;
  assign bus.out_regwrite    = q.regwrite;
  assign bus.out_memtoreg    = q.memtoreg;
  assign bus.out_memwrite    = q.memwrite;
  assign bus.out_alusrcbimm  = q.alusrcbimm;
  assign bus.out_slt         = q.slt;
  assign bus.out_shift16left = q.shift16left;
  assign bus.out_zeroextend  = q.zeroextend;
  assign bus.out_dojal       = q.dojal;
  assign bus.out_dojr        = q.dojr;
  assign bus.out_dojump      = q.dojump;
  assign bus.out_isbranch    = q.isbranch;
  assign bus.out_branchneg   = q.branchneg;
  assign bus.out_destreg     = q.destreg;
  assign bus.out_alucontrol  = q.alucontrol;
  assign bus.out_illegal     = q.illegal;
  assign bus.muldiv_start    = start;
  assign bus.muldiv_busy     = cnt != 8'd0;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed checks of two decode_stage variants against a transaction model
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iv = 1'b0, fl = 1'b0, ordy = 1'b0;
  logic [31:0] ins = '0, ipc = '0;
  int          n_chk = 0, n_fail = 0;
  decode_if b0 ();
  decode_if b1 ();
  decode_stage #(.MULDIV_CYCLES(8), .LOAD_USE_INTERLOCK(1'b1)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  decode_stage #(.MULDIV_CYCLES(3), .LOAD_USE_INTERLOCK(1'b0)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  always #5 clk = ~clk;
  assign b0.in_valid = iv;
  assign b0.in_instr = ins;
  assign b0.in_pc = ipc;
  assign b0.flush = fl;
  assign b0.out_ready = ordy;
  assign b1.in_valid = iv;
  assign b1.in_instr = ins;
  assign b1.in_pc = ipc;
  assign b1.flush = fl;
  assign b1.out_ready = ordy;
  logic        obs_valid[2], obs_ready[2], obs_start[2], obs_busy[2];
  logic [20:0] obs_ctrl[2];
  logic [31:0] obs_instr[2], obs_pc[2];
  assign obs_valid[0] = b0.out_valid;
  assign obs_ready[0] = b0.in_ready;
  assign obs_start[0] = b0.muldiv_start;
  assign obs_busy[0]  = b0.muldiv_busy;
  assign obs_instr[0] = b0.out_instr;
  assign obs_pc[0]    = b0.out_pc;
  assign obs_ctrl[0]  = {b0.out_illegal, b0.out_regwrite, b0.out_memtoreg, b0.out_memwrite,
                         b0.out_alusrcbimm, b0.out_slt, b0.out_shift16left, b0.out_zeroextend,
                         b0.out_dojal, b0.out_dojr, b0.out_dojump, b0.out_isbranch,
                         b0.out_branchneg, b0.out_destreg, b0.out_alucontrol};
  assign obs_valid[1] = b1.out_valid;
  assign obs_ready[1] = b1.in_ready;
  assign obs_start[1] = b1.muldiv_start;
  assign obs_busy[1]  = b1.muldiv_busy;
  assign obs_instr[1] = b1.out_instr;
  assign obs_pc[1]    = b1.out_pc;
  assign obs_ctrl[1]  = {b1.out_illegal, b1.out_regwrite, b1.out_memtoreg, b1.out_memwrite,
                         b1.out_alusrcbimm, b1.out_slt, b1.out_shift16left, b1.out_zeroextend,
                         b1.out_dojal, b1.out_dojr, b1.out_dojump, b1.out_isbranch,
                         b1.out_branchneg, b1.out_destreg, b1.out_alucontrol};
  logic        m_valid[2], m_start[2];
  logic [31:0] m_instr[2], m_pc[2];
  int          m_cnt[2];
  logic        last_valid[2], last_ready[2], last_start[2], last_x[2];
  logic [20:0] last_ctrl[2];
  logic [31:0] last_pc[2];
  localparam logic [31:0] MULU  = 32'h0043_0019;
  localparam logic [31:0] MFLO  = 32'h0000_2012;
  localparam logic [31:0] LW    = 32'h8C89_0000;
  localparam logic [31:0] ADDU  = 32'h012B_5021;
  localparam logic [31:0] BEQ   = 32'h1022_0003;
  localparam logic [31:0] ADDIU = 32'h2408_0005;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int mc(input int k);
    return k == 0 ? 8 : 3;
  endfunction
  function automatic logic [20:0] exp_dec(input logic [31:0] w);
    logic [5:0] op, fn;
    logic ill, rw, mtr, mw, imm, slt, s16, zx, jal, jr, jmp, br, bn;
    logic [4:0] dst;
    logic [2:0] alu;
    op = w[31:26];
    fn = w[5:0];
    {ill, rw, mtr, mw, imm, slt, s16, zx, jal, jr, jmp, br, bn, dst, alu} = '0;
    if (op == 6'h00) begin
      rw = 1'b1;
      dst = w[15:11];
      if (fn == 6'h21) alu = 3'd2;
      else if (fn == 6'h23) alu = 3'd6;
      else if (fn == 6'h24) alu = 3'd0;
      else if (fn == 6'h25) alu = 3'd1;
      else if (fn == 6'h1b) alu = 3'd7;
      else if (fn == 6'h19) alu = 3'd3;
      else if (fn == 6'h10) alu = 3'd4;
      else if (fn == 6'h12) alu = 3'd5;
      else if (fn == 6'h2b) slt = 1'b1;
      else if (fn == 6'h08) begin rw = 1'b0; dst = 5'd0; jr = 1'b1; end
      else ill = 1'b1;
    end
    else if (op == 6'h23) begin rw = 1'b1; mtr = 1'b1; imm = 1'b1; alu = 3'd2; dst = w[20:16]; end
    else if (op == 6'h2b) begin mw = 1'b1; imm = 1'b1; alu = 3'd2; end
    else if (op == 6'h04) begin br = 1'b1; alu = 3'd6; end
    else if (op == 6'h01) begin br = 1'b1; slt = 1'b1; bn = 1'b1; end
    else if (op == 6'h09) begin rw = 1'b1; imm = 1'b1; alu = 3'd2; dst = w[20:16]; end
    else if (op == 6'h0d) begin rw = 1'b1; zx = 1'b1; imm = 1'b1; alu = 3'd1; dst = w[20:16]; end
    else if (op == 6'h0f) begin rw = 1'b1; s16 = 1'b1; imm = 1'b1; alu = 3'd2; dst = w[20:16]; end
    else if (op == 6'h02) jmp = 1'b1;
    else if (op == 6'h03) begin jmp = 1'b1; jal = 1'b1; rw = 1'b1; dst = 5'd31; end
    else ill = 1'b1;
    if (ill) return {1'b1, 20'd0};
    return {ill, rw, mtr, mw, imm, slt, s16, zx, jal, jr, jmp, br, bn, dst, alu};
  endfunction
  function automatic logic [31:0] gen();
    logic [5:0] fns[10];
    logic [5:0] ops[9];
    int r;
    logic [4:0] rs, rt, rd;
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2b, 6'h08, 6'h19, 6'h1b, 6'h10, 6'h12};
    ops = '{6'h23, 6'h2b, 6'h04, 6'h01, 6'h09, 6'h0d, 6'h0f, 6'h02, 6'h03};
    r = $urandom_range(0, 21);
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    if (r < 10) return {6'h00, rs, rt, rd, 5'd0, fns[r]};
    if (r < 19) return {ops[r-10], rs, rt, 16'($urandom)};
    return $urandom;
  endfunction
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p, input logic f, input logic r);
    logic        n_valid[2], n_start[2];
    logic [31:0] n_instr[2], n_pc[2];
    int          n_cnt[2];
    @(negedge clk);
    iv = v; ins = w; ipc = p; fl = f; ordy = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] h;
      logic md, hl, ur, lu, er, acc;
      h = m_instr[k];
      md = w[31:26] == 6'h00 && (w[5:0] == 6'h19 || w[5:0] == 6'h1b);
      hl = w[31:26] == 6'h00 && (w[5:0] == 6'h10 || w[5:0] == 6'h12);
      ur = w[31:26] == 6'h00 || w[31:26] == 6'h04 || w[31:26] == 6'h2b;
      lu = k == 0 && m_valid[k] && h[31:26] == 6'h23 && h[20:16] != 5'd0 &&
           (h[20:16] == w[25:21] || (ur && h[20:16] == w[20:16]));
      er = !f && !(m_cnt[k] != 0 && (md || hl)) && !lu && (!m_valid[k] || r);
      acc = v && er;
      check($sformatf("in_ready%0d", k), obs_ready[k], er);
      check($sformatf("out_valid%0d", k), obs_valid[k], m_valid[k]);
      check($sformatf("busy%0d", k), obs_busy[k], m_cnt[k] != 0);
      check($sformatf("start%0d", k), obs_start[k], m_start[k]);
      if (m_valid[k]) begin
        check($sformatf("ctrl%0d", k), obs_ctrl[k], exp_dec(m_instr[k]));
        check($sformatf("instr%0d", k), obs_instr[k], m_instr[k]);
        check($sformatf("pc%0d", k), obs_pc[k], m_pc[k]);
      end
      last_valid[k] = obs_valid[k];
      last_ready[k] = obs_ready[k];
      last_start[k] = obs_start[k];
      last_ctrl[k]  = obs_ctrl[k];
      last_pc[k]    = obs_pc[k];
      last_x[k]     = $isunknown({obs_valid[k], obs_ready[k], obs_start[k], obs_busy[k],
                                  obs_ctrl[k], obs_instr[k], obs_pc[k]});
      n_start[k] = acc && md;
      n_cnt[k]   = (acc && md) ? mc(k) : (m_cnt[k] > 0 ? m_cnt[k] - 1 : 0);
      n_valid[k] = acc ? 1'b1 : (f || r) ? 1'b0 : m_valid[k];
      n_instr[k] = acc ? w : m_instr[k];
      n_pc[k]    = acc ? p : m_pc[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = n_valid[k];
      m_start[k] = n_start[k];
      m_cnt[k]   = n_cnt[k];
      m_instr[k] = n_instr[k];
      m_pc[k]    = n_pc[k];
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_start[k] = 1'b0; m_cnt[k] = 0; m_instr[k] = '0; m_pc[k] = '0;
    end
  endtask
  task automatic reset_hold();
    iv = 1'b1; ins = MULU; fl = 1'b0; ordy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        check($sformatf("reset_zero%0d", k),
              {obs_valid[k], obs_start[k], obs_busy[k], obs_ctrl[k], obs_instr[k], obs_pc[k]}, '0);
    end
    @(negedge clk);
    iv = 1'b0;
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("ready_after_reset%0d", k), obs_ready[k], 1'b1);
  endtask
  task automatic drain();
    repeat (12) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask
  initial begin
    int stalls, starts;
    logic got;
    model_reset();
    reset_hold();
    step(1'b1, ADDIU, 32'h40, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("addiu_valid", last_valid[0], 1'b1);
    check("addiu_ctrl", last_ctrl[0], 21'b0_1001_0000_0000_01000_010);
    drain();
    step(1'b1, MULU, 32'h80, 1'b0, 1'b1);
    stalls = 0; starts = 0; got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step(1'b1, MFLO, 32'h84, 1'b0, 1'b1);
      starts += int'(last_start[0]);
      if (last_ready[0]) got = 1'b1;
      else stalls++;
    end
    check("mflo_accepted", got, 1'b1);
    check("mflo_stall_cycles", stalls, 8);
    check("mulu_start_pulses", starts, 1);
    drain();
    step(1'b1, LW, 32'hA0, 1'b0, 1'b1);
    step(1'b1, ADDU, 32'hA4, 1'b0, 1'b1);
    check("lu_lw_out", last_valid[0], 1'b1);
    check("lu_stall", last_ready[0], 1'b0);
    check("nolu_ready", last_ready[1], 1'b1);
    step(1'b1, ADDU, 32'hA4, 1'b0, 1'b1);
    check("lu_bubble", last_valid[0], 1'b0);
    check("lu_accept", last_ready[0], 1'b1);
    check("nolu_no_bubble", last_valid[1], 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("lu_consumer_out", last_valid[0], 1'b1);
    drain();
    step(1'b1, BEQ, 32'h100, 1'b0, 1'b1);
    repeat (4) begin
      step(1'b1, ADDIU, 32'h104, 1'b0, 1'b0);
      check("held_pc", last_pc[0], 32'h100);
      check("held_ready", last_ready[0], 1'b0);
      check("held_ctrl", last_ctrl[0], exp_dec(BEQ));
    end
    step(1'b1, ADDIU, 32'h104, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("flush_clears", last_valid[0], 1'b0);
    step(1'b1, 32'hFC00_0000, 32'h200, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("illegal_valid", last_valid[0], 1'b1);
    check("illegal_ctrl", last_ctrl[0], {1'b1, 20'd0});
    check("illegal_no_x", last_x[0], 1'b0);
    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 3) != 0, gen(), $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    drain();
    step(1'b1, MULU, 32'h300, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid_clear", obs_valid[0], 1'b0);
    check("async_busy_clear", obs_busy[0], 1'b0);
    check("async_busy_clear1", obs_busy[1], 1'b0);
    model_reset();
    reset_hold();
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 3) != 0, gen(), $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
